// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: pixel width, Q-format and signed pixel type
// used by leaky_relu and max_pool_2x2.
package cnn_pkg;

  localparam int DATA_W = 8;
  localparam int FRAC   = 4;

  typedef logic signed [DATA_W-1:0] pixel_t;

  function automatic pixel_t pixel_max(input pixel_t a, input pixel_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer for 2x2 pooling: stores per-column-pair maxima of the
// even row. One synchronous write port, one combinational read port.
module pool_line_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  // Contents are don't-care after reset: every slot is rewritten on the even
  // row before it is read on the following odd row.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 stride-2 signed max pooling over a raster-order pixel stream,
// one pooled pixel per window with a frame-end marker.
module max_pool_2x2 #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int LB_D  = IMG_W / 2;
  localparam int IDX_W = (LB_D > 1) ? $clog2(LB_D) : 1;

  logic [COL_W-1:0] col, col_half;
  logic [ROW_W-1:0] row;
  logic [IDX_W-1:0] lb_idx;
  logic signed [DATA_W-1:0] px, hold, lb_rd, pair_max, win_max;
  logic col_end, row_end, lb_we, win_done;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign px       = in_data;
  assign col_end  = (col == COL_W'(IMG_W - 1));
  assign row_end  = (row == ROW_W'(IMG_H - 1));
  assign col_half = col >> 1;
  assign lb_idx   = col_half[IDX_W-1:0];

  // Even row stores the pair max; odd row folds it into the window result.
  assign pair_max = smax(hold, px);
  assign win_max  = smax(pair_max, lb_rd);
  assign lb_we    = in_valid & col[0] & ~row[0];
  assign win_done = in_valid & col[0] & row[0];

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (LB_D),
    .IDX_W  (IDX_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_idx),
    .wdata (pair_max),
    .raddr (lb_idx),
    .rdata (lb_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      hold      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (in_valid) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) hold <= px;
      end
      if (win_done) begin
        out_data  <= win_max;
        out_valid <= 1'b1;
        out_last  <= col_end & row_end;
      end
    end
  end

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2 (4x4 frames): stimulus pushes expected
// outputs with their due cycle, a negedge monitor pops and compares.
module tb_max_pool_2x2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;

  typedef struct {
    logic signed [7:0] d;
    logic              l;
    int                c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  logic signed [7:0] last_exp = '0;

  logic signed [7:0] px [16];
  logic signed [7:0] ex [4];

  max_pool_2x2 #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: reset state, scoreboard pops on out_valid, hold/idle otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0)
        $display("FAIL reset_state: valid=%b data=%0d last=%b, want 0/0/0",
                 out_valid, $signed(out_data), out_last);
      else passes++;
      last_exp = '0;
    end else if (out_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_out: data=%0d last=%b at cycle %0d, want no output",
                 $signed(out_data), out_last, cyc);
      end else begin
        e = q.pop_front();
        if ($signed(out_data) !== e.d || out_last !== e.l || cyc != e.c)
          $display("FAIL pooled_out: data=%0d last=%b cycle=%0d, want data=%0d last=%b cycle=%0d",
                   $signed(out_data), out_last, cyc, e.d, e.l, e.c);
        else passes++;
        last_exp = e.d;
      end
    end else begin
      checks++;
      if ($signed(out_data) !== last_exp || out_last !== 1'b0)
        $display("FAIL idle_hold: data=%0d last=%b, want data=%0d last=0",
                 $signed(out_data), out_last, last_exp);
      else passes++;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'h55;
    end
  endtask

  // Drives one 4x4 frame; beats at odd col of odd row complete a window.
  task automatic send_frame(input bit gap);
    int k = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      in_data  = px[i];
      in_valid = 1'b1;
      if ((i % 4) % 2 == 1 && (i / 4) % 2 == 1) begin
        q.push_back('{d: ex[k], l: (i == 15), c: cyc + 1});
        k++;
      end
      if (gap) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'h7F;
      end
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) px[i] = 8'(i);
    ex = '{8'sd5, 8'sd7, 8'sd13, 8'sd15};
  endtask

  initial begin
    int budget;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // 1: ramp
    load_ramp();
    send_frame(1'b0);
    idle(3);

    // 2: all -16, one -1 per window
    for (int i = 0; i < 16; i++) px[i] = -8'sd16;
    px[4] = -8'sd1; px[3] = -8'sd1; px[13] = -8'sd1; px[10] = -8'sd1;
    ex = '{-8'sd1, -8'sd1, -8'sd1, -8'sd1};
    send_frame(1'b0);
    idle(3);

    // 3: ramp with in_valid toggling
    load_ramp();
    send_frame(1'b1);
    idle(3);

    // 4: back-to-back frames, second is -(16+i)
    load_ramp();
    send_frame(1'b0);
    for (int i = 0; i < 16; i++) px[i] = -8'(16 + i);
    ex = '{-8'sd16, -8'sd18, -8'sd24, -8'sd26};
    send_frame(1'b0);
    idle(3);

    // 5: reset mid-frame after 6 beats (beat 5 already completes window 0)
    load_ramp();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_data = px[i]; in_valid = 1'b1;
      if (i == 5) q.push_back('{d: 8'sd5, l: 1'b0, c: cyc + 1});
    end
    idle(2);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(1'b0);
    idle(3);

    // 6: +127 at TL, TR, BL, BR of the four windows
    for (int i = 0; i < 16; i++) px[i] = 8'sd0;
    px[0] = 8'sd127; px[3] = 8'sd127; px[12] = 8'sd127; px[15] = 8'sd127;
    ex = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
    send_frame(1'b0);

    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      idle(1);
      budget++;
    end
    idle(2);
    checks++;
    if (q.size() != 0)
      $display("FAIL drain: %0d outputs still pending, want 0", q.size());
    else passes++;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
